// File: rtl/log_motion_ctrl.sv
// Once per frame, sweeps all logs (one per cycle) and advances each by its lane speed with horizontal wrap.
// The whole X set is then committed at once, so the renderer only ever sees complete frames.
module log_motion_ctrl #(
  parameter int NUM_OF_LOGS   = 30,
  parameter int NUM_LANES     = 6,
  parameter int LOGS_PER_LANE = 5,
  parameter int SCREEN_W      = 640,
  parameter int X_SPACING     = 128,
  parameter int LANE_STAGGER  = 40,
  parameter int LANE_Y0       = 80,
  parameter int LANE_H        = 20
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        startOfFrame,
  input  logic        pause,
  input  logic        restart,
  output logic [10:0] ObjectStartX [NUM_OF_LOGS],
  output logic [10:0] ObjectStartY [NUM_OF_LOGS],
  output logic        busy,
  output logic        update_done,
  output logic        frame_overrun
);

  localparam int IDX_W  = $clog2(NUM_OF_LOGS);
  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int SLOT_W = $clog2(LOGS_PER_LANE);

  typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [LANE_W-1:0]   lane;
  logic [SLOT_W-1:0]   slot;
  logic [10:0]         work [NUM_OF_LOGS];

  function automatic logic [10:0] init_x(input int i);
    int l;
    int s;
    l = i / LOGS_PER_LANE;
    s = i % LOGS_PER_LANE;
    return 11'((s * X_SPACING + l * LANE_STAGGER) % SCREEN_W);
  endfunction

  function automatic logic [10:0] init_y(input int i);
    return 11'(LANE_Y0 + (i / LOGS_PER_LANE) * LANE_H);
  endfunction

  // Even lanes drift right, odd lanes left; speed cycles 1,2,3 px/frame across lanes.
  function automatic logic [10:0] step_x(input logic [10:0] x, input logic [LANE_W-1:0] l);
    logic [10:0] spd;
    logic [10:0] n;
    spd = 11'(l % 3) + 11'd1;
    if (!l[0]) begin
      n = x + spd;
      if (n >= 11'(SCREEN_W)) n = n - 11'(SCREEN_W);
    end else begin
      n = (x < spd) ? x + 11'(SCREEN_W) - spd : x - spd;
    end
    return n;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_OF_LOGS; i++) ObjectStartY[i] = init_y(i);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state         <= IDLE;
      idx           <= '0;
      lane          <= '0;
      slot          <= '0;
      busy          <= 1'b0;
      update_done   <= 1'b0;
      frame_overrun <= 1'b0;
      for (int i = 0; i < NUM_OF_LOGS; i++) begin
        work[i]         <= init_x(i);
        ObjectStartX[i] <= init_x(i);
      end
    end else begin
      update_done <= 1'b0;
      if (restart) begin
        state         <= IDLE;
        idx           <= '0;
        lane          <= '0;
        slot          <= '0;
        busy          <= 1'b0;
        frame_overrun <= 1'b0;
        for (int i = 0; i < NUM_OF_LOGS; i++) begin
          work[i]         <= init_x(i);
          ObjectStartX[i] <= init_x(i);
        end
      end else begin
        case (state)
          IDLE: begin
            if (startOfFrame && !pause) begin
              state <= UPDATE;
              idx   <= '0;
              lane  <= '0;
              slot  <= '0;
              busy  <= 1'b1;
            end
          end
          UPDATE: begin
            if (startOfFrame) frame_overrun <= 1'b1;
            work[idx] <= step_x(work[idx], lane);
            if (idx == IDX_W'(NUM_OF_LOGS - 1)) begin
              state <= COMMIT;
            end else begin
              idx <= idx + 1'b1;
              if (slot == SLOT_W'(LOGS_PER_LANE - 1)) begin
                slot <= '0;
                lane <= lane + 1'b1;
              end else begin
                slot <= slot + 1'b1;
              end
            end
          end
          COMMIT: begin
            if (startOfFrame) frame_overrun <= 1'b1;
            ObjectStartX <= work;
            update_done  <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_log_motion_ctrl.sv
// Randomized frame sequences for log_motion_ctrl, checked against a per-log position model.
module tb_log_motion_ctrl;

  localparam int N = 30;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        pause = 1'b0;
  logic        restart = 1'b0;
  logic [10:0] ObjectStartX [N];
  logic [10:0] ObjectStartY [N];
  logic        busy;
  logic        update_done;
  logic        frame_overrun;

  int n_chk = 0;
  int n_fail = 0;
  int mx [N];
  bit m_ovr = 0;

  log_motion_ctrl dut (
    .CLK(CLK), .RESETn(RESETn), .startOfFrame(startOfFrame), .pause(pause), .restart(restart),
    .ObjectStartX(ObjectStartX), .ObjectStartY(ObjectStartY),
    .busy(busy), .update_done(update_done), .frame_overrun(frame_overrun)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_init();
    for (int i = 0; i < N; i++) mx[i] = ((i % 5) * 128 + (i / 5) * 40) % 640;
  endfunction

  function automatic void model_frame();
    for (int i = 0; i < N; i++) begin
      int l = i / 5;
      int spd = (l % 3) + 1;
      if (l % 2 == 0) mx[i] = (mx[i] + spd) % 640;
      else            mx[i] = (mx[i] - spd + 640) % 640;
    end
  endfunction

  task automatic compare_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_x%0d", tag, i), int'(ObjectStartX[i]), mx[i]);
      check($sformatf("%s_y%0d", tag, i), int'(ObjectStartY[i]), 80 + 20 * (i / 5));
    end
  endtask

  // One startOfFrame, optionally with an overrun pulse, a restart or an async reset at sweep cycle c.
  task automatic do_frame(input bit p, input int ovr_at, input int rst_at, input int arst_at,
                          input bit per_cycle);
    int bcnt = 0;
    int dcnt = 0;
    bit done_seen = 0;
    bit rs = 0;
    @(negedge CLK);
    startOfFrame = 1'b1;
    pause = p;
    @(negedge CLK);
    startOfFrame = 1'b0;
    pause = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rst_at >= 0 && c == rst_at + 1) begin
        model_init();
        m_ovr = 0;
        rs = 1;
        check("restart_busy", int'(busy), 0);
        check("restart_done", int'(update_done), 0);
      end
      if (update_done) begin
        dcnt++;
        if (!done_seen) begin
          model_frame();
          done_seen = 1;
        end
      end
      if (busy) bcnt++;
      if (per_cycle) compare_all("cyc");
      if (c == arst_at) begin
        #2 RESETn = 1'b0;
        #1;
        model_init();
        m_ovr = 0;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(update_done), 0);
        check("arst_ovr", int'(frame_overrun), 0);
        compare_all("arst");
        @(negedge CLK);
        RESETn = 1'b1;
        return;
      end
      startOfFrame = (c == ovr_at);
      if (c == ovr_at) m_ovr = 1;
      restart = (c == rst_at);
      @(negedge CLK);
    end
    startOfFrame = 1'b0;
    restart = 1'b0;
    check("busy_cycles", bcnt, p ? 0 : (rs ? rst_at + 1 : 31));
    check("done_pulses", dcnt, (p || rs) ? 0 : 1);
    check("overrun", int'(frame_overrun), int'(m_ovr));
    compare_all("frame");
  endtask

  initial begin
    model_init();
    repeat (3) @(negedge CLK);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(update_done), 0);
    check("rst_ovr", int'(frame_overrun), 0);
    check("rst_log0_x", int'(ObjectStartX[0]), 0);
    check("rst_log0_y", int'(ObjectStartY[0]), 80);
    check("rst_log5_x", int'(ObjectStartX[5]), 40);
    check("rst_log5_y", int'(ObjectStartY[5]), 100);
    check("rst_log29_x", int'(ObjectStartX[29]), 72);
    check("rst_log29_y", int'(ObjectStartY[29]), 180);
    RESETn = 1'b1;
    @(negedge CLK);
    compare_all("reset");

    do_frame(0, -1, -1, -1, 1);
    check("f1_log0_x", int'(ObjectStartX[0]), 1);
    check("f1_log5_x", int'(ObjectStartX[5]), 38);

    do_frame(1, -1, -1, -1, 1);
    do_frame(0, 5, -1, -1, 1);
    do_frame(0, -1, -1, -1, 0);
    do_frame(0, -1, 10, -1, 1);

    for (int f = 1; f <= 128; f++) begin
      do_frame(0, -1, -1, -1, 0);
      if (f == 20)  check("wrap_log5_f20", int'(ObjectStartX[5]), 0);
      if (f == 21)  check("wrap_log5_f21", int'(ObjectStartX[5]), 638);
      if (f == 127) check("wrap_log4_f127", int'(ObjectStartX[4]), 639);
      if (f == 128) check("wrap_log4_f128", int'(ObjectStartX[4]), 0);
    end

    for (int k = 0; k < 25; k++) begin
      bit p;
      int ovr;
      int rst;
      p = ($urandom_range(0, 3) == 0);
      ovr = (!p && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, 29)) : -1;
      rst = (!p && ovr < 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, 29)) : -1;
      do_frame(p, ovr, rst, -1, 0);
    end

    do_frame(0, -1, -1, 12, 0);
    do_frame(0, -1, -1, -1, 1);
    check("post_arst_log0_x", int'(ObjectStartX[0]), 1);
    check("post_arst_log5_x", int'(ObjectStartX[5]), 38);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
